// File: rtl/xy_point_player.sv
// -----------------------------------------------------------------------------
// xy_point_player
//
// Plays a loadable list of XY points out to the vector-display DAC buses.
// Points arrive as a byte stream while playback is parked (enable_i low) and
// are stored in a small RAM. While enabled, a programmable divider paces the
// player, which steps through the list in loop, one-shot, ping-pong or hold
// mode.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   enable_i      1 = play, 0 = park outputs and allow loading
//   div_val_i     a tick occurs every div_val_i+1 clocks
//   mode_i        00 loop, 01 one-shot, 10 ping-pong, 11 hold
//   load_start_i  clears the point list (only while parked)
//   load_valid_i  byte-stream valid
//   load_data_i   byte-stream data
//   load_ready_o  byte accepted when load_valid_i & load_ready_o
//   xdac_o        registered X DAC code
//   ydac_o        registered Y DAC code
//   point_idx_o   index of the point currently on the DAC
//   npts_o        committed point count
//   blank_o       high when not actively playing
//   frame_done_o  one-cycle pulse at end of frame
// -----------------------------------------------------------------------------
module xy_point_player #(
    parameter int COORD_W = 8,
    parameter int DEPTH   = 64,
    parameter int DIV_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic [DIV_W-1:0]         div_val_i,
    input  logic [1:0]               mode_i,
    input  logic                     load_start_i,
    input  logic                     load_valid_i,
    input  logic [7:0]               load_data_i,
    output logic                     load_ready_o,
    output logic [COORD_W-1:0]       xdac_o,
    output logic [COORD_W-1:0]       ydac_o,
    output logic [$clog2(DEPTH)-1:0] point_idx_o,
    output logic [$clog2(DEPTH):0]   npts_o,
    output logic                     blank_o,
    output logic                     frame_done_o
);

    localparam int IW   = $clog2(DEPTH);
    localparam int BPC  = (COORD_W + 7) / 8;
    localparam int NB   = 2 * BPC;          // bytes per point
    localparam int PH_W = $clog2(NB);

    localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(NB - 1);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1'b1);
    localparam logic [IW:0]      NPTS_MAX = (IW + 1)'(DEPTH);
    localparam logic [IW:0]      NPTS_ONE = (IW + 1)'(1'b1);
    localparam logic [IW-1:0]    IDX_ONE  = IW'(1'b1);
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1'b1);

    localparam logic [1:0] MODE_LOOP     = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // ---------------------------------------------------------------- loader
    logic [IW:0]        npts_q, npts_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [NB*8-1:0]    asm_q, asm_d;
    logic [NB*8-1:0]    asm_merge_s;
    logic               load_ready_s;
    logic               accept_s;
    logic               wr_en_s;
    logic [COORD_W-1:0] wr_x_s;
    logic [COORD_W-1:0] wr_y_s;
    logic [2*COORD_W-1:0] mem_q [DEPTH];

    assign load_ready_s = !enable_i && (npts_q < NPTS_MAX);
    // load_start wins over a coincident byte, so the byte is dropped.
    assign accept_s     = load_valid_i && load_ready_s && !load_start_i;
    assign wr_en_s      = accept_s && (phase_q == LAST_PH);

    // Byte assembly: current byte merged into its slot so the final Y byte
    // can be written straight through to RAM in the same cycle.
    always_comb begin
        asm_merge_s = asm_q;
        for (int b = 0; b < NB; b++) begin
            if (phase_q == PH_W'(b)) begin
                asm_merge_s[b*8 +: 8] = load_data_i;
            end else begin
                asm_merge_s[b*8 +: 8] = asm_q[b*8 +: 8];
            end
        end
    end

    // Bits above COORD_W in each coordinate are simply not picked up here.
    assign wr_x_s = asm_merge_s[COORD_W-1:0];
    assign wr_y_s = asm_merge_s[BPC*8 +: COORD_W];

    // Loader next-state: point count, byte phase and assembly buffer.
    always_comb begin
        npts_d  = npts_q;
        phase_d = phase_q;
        asm_d   = asm_q;
        if (load_start_i && !enable_i) begin
            npts_d  = {(IW + 1){1'b0}};
            phase_d = {PH_W{1'b0}};
        end else if (accept_s) begin
            asm_d = asm_merge_s;
            if (phase_q == LAST_PH) begin
                phase_d = {PH_W{1'b0}};
                npts_d  = npts_q + NPTS_ONE;
            end else begin
                phase_d = phase_q + PH_ONE;
            end
        end else begin
            npts_d  = npts_q;
            phase_d = phase_q;
        end
    end

    // Loader registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            npts_q  <= {(IW + 1){1'b0}};
            phase_q <= {PH_W{1'b0}};
            asm_q   <= {(NB * 8){1'b0}};
        end else begin
            npts_q  <= npts_d;
            phase_q <= phase_d;
            asm_q   <= asm_d;
        end
    end

    // Point RAM; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[npts_q[IW-1:0]] <= {wr_y_s, wr_x_s};
        end
    end

    // ---------------------------------------------------------------- player
    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               dir_up_q, dir_up_d;
    logic [COORD_W-1:0] xdac_q, xdac_d;
    logic [COORD_W-1:0] ydac_q, ydac_d;
    logic [IW-1:0]      pidx_q, pidx_d;
    logic               blank_q, blank_d;
    logic               fd_q, fd_d;

    logic               tick_s;
    logic [IW:0]        last_s;
    logic               at_last_s;
    logic               at_first_s;
    logic               single_s;
    logic [2*COORD_W-1:0] rd_word_s;

    assign tick_s     = (state_q == ST_PLAY) && (cnt_q == div_val_i);
    assign last_s     = npts_q - NPTS_ONE;
    assign at_last_s  = ({1'b0, idx_q} == last_s);
    assign at_first_s = (idx_q == {IW{1'b0}});
    assign single_s   = (npts_q == NPTS_ONE);
    assign rd_word_s  = mem_q[idx_q];

    // Player next-state: FSM, divider, index/direction and DAC outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        dir_up_d = dir_up_q;
        xdac_d   = xdac_q;
        ydac_d   = ydac_q;
        pidx_d   = pidx_q;
        blank_d  = blank_q;
        fd_d     = 1'b0;
        if (!enable_i) begin
            state_d  = ST_IDLE;
            cnt_d    = {DIV_W{1'b0}};
            idx_d    = {IW{1'b0}};
            dir_up_d = 1'b1;
            xdac_d   = {COORD_W{1'b0}};
            ydac_d   = {COORD_W{1'b0}};
            pidx_d   = {IW{1'b0}};
            blank_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = {DIV_W{1'b0}};
                    blank_d = 1'b1;
                    if (npts_q != {(IW + 1){1'b0}}) begin
                        state_d = ST_PLAY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (tick_s) begin
                        cnt_d   = {DIV_W{1'b0}};
                        xdac_d  = rd_word_s[COORD_W-1:0];
                        ydac_d  = rd_word_s[2*COORD_W-1:COORD_W];
                        pidx_d  = idx_q;
                        blank_d = 1'b0;
                        case (mode_i)
                            MODE_LOOP: begin
                                dir_up_d = 1'b1;
                                fd_d     = at_last_s;
                                if (at_last_s) begin
                                    idx_d = {IW{1'b0}};
                                end else begin
                                    idx_d = idx_q + IDX_ONE;
                                end
                            end
                            MODE_ONESHOT: begin
                                dir_up_d = 1'b1;
                                if (at_last_s) begin
                                    // Last point stays on the DAC, blanked.
                                    fd_d    = 1'b1;
                                    blank_d = 1'b1;
                                    state_d = ST_DONE;
                                    idx_d   = idx_q;
                                end else begin
                                    idx_d = idx_q + IDX_ONE;
                                end
                            end
                            MODE_PINGPONG: begin
                                if (single_s) begin
                                    // One point: every output completes a frame.
                                    fd_d     = 1'b1;
                                    idx_d    = {IW{1'b0}};
                                    dir_up_d = 1'b1;
                                end else if (dir_up_q) begin
                                    if (at_last_s) begin
                                        dir_up_d = 1'b0;
                                        idx_d    = idx_q - IDX_ONE;
                                    end else begin
                                        idx_d = idx_q + IDX_ONE;
                                    end
                                end else begin
                                    if (at_first_s) begin
                                        // Point 0 on the return sweep ends the frame.
                                        fd_d     = 1'b1;
                                        dir_up_d = 1'b1;
                                        idx_d    = idx_q + IDX_ONE;
                                    end else begin
                                        idx_d = idx_q - IDX_ONE;
                                    end
                                end
                            end
                            MODE_HOLD: begin
                                // Refresh only; upward so a later ping-pong starts up.
                                idx_d    = idx_q;
                                dir_up_d = 1'b1;
                            end
                            default: begin
                                idx_d = idx_q;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    cnt_d   = {DIV_W{1'b0}};
                    blank_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {DIV_W{1'b0}};
                    blank_d = 1'b1;
                end
            endcase
        end
    end

    // Player registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {DIV_W{1'b0}};
            idx_q    <= {IW{1'b0}};
            dir_up_q <= 1'b1;
            xdac_q   <= {COORD_W{1'b0}};
            ydac_q   <= {COORD_W{1'b0}};
            pidx_q   <= {IW{1'b0}};
            blank_q  <= 1'b1;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dir_up_q <= dir_up_d;
            xdac_q   <= xdac_d;
            ydac_q   <= ydac_d;
            pidx_q   <= pidx_d;
            blank_q  <= blank_d;
            fd_q     <= fd_d;
        end
    end

    assign load_ready_o = load_ready_s;
    assign xdac_o       = xdac_q;
    assign ydac_o       = ydac_q;
    assign point_idx_o  = pidx_q;
    assign npts_o       = npts_q;
    assign blank_o      = blank_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_xy_point_player.sv
// -----------------------------------------------------------------------------
// Testbench for xy_point_player.
// dut_a: COORD_W=8, DEPTH=64 (playback modes, abort, divider edge cases).
// dut_b: COORD_W=12, DEPTH=4 (multi-byte coordinates, load limits, load_start).
// Playback on dut_a is checked by a scoreboard: expected output events
// (cycle, point, blank, frame_done) are queued when a scenario starts, and a
// monitor process compares them whenever the DUT outputs change.
// -----------------------------------------------------------------------------
module tb_xy_point_player;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] div_val;
    logic [1:0]  mode;

    logic        a_enable, a_load_start, a_load_valid;
    logic [7:0]  a_load_data;
    logic        a_load_ready;
    logic [7:0]  a_xdac, a_ydac;
    logic [5:0]  a_pidx;
    logic [6:0]  a_npts;
    logic        a_blank, a_fd;

    logic        b_enable, b_load_start, b_load_valid;
    logic [7:0]  b_load_data;
    logic        b_load_ready;
    logic [11:0] b_xdac, b_ydac;
    logic [1:0]  b_pidx;
    logic [2:0]  b_npts;
    logic        b_blank, b_fd;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cyc = 0;
    logic mon_on = 1'b0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [5:0]  idx;
        logic        blank;
        logic        fd;
    } ev_t;

    ev_t exp_q[$];

    int         pp_seq [7]  = '{0, 1, 2, 1, 0, 1, 2};
    logic [7:0] b_fill [12] = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00,
                                8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00};

    xy_point_player #(.COORD_W(8), .DEPTH(64), .DIV_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable_i(a_enable), .div_val_i(div_val),
        .mode_i(mode), .load_start_i(a_load_start), .load_valid_i(a_load_valid),
        .load_data_i(a_load_data), .load_ready_o(a_load_ready),
        .xdac_o(a_xdac), .ydac_o(a_ydac), .point_idx_o(a_pidx),
        .npts_o(a_npts), .blank_o(a_blank), .frame_done_o(a_fd)
    );

    xy_point_player #(.COORD_W(12), .DEPTH(4), .DIV_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable_i(b_enable), .div_val_i(div_val),
        .mode_i(mode), .load_start_i(b_load_start), .load_valid_i(b_load_valid),
        .load_data_i(b_load_data), .load_ready_o(b_load_ready),
        .xdac_o(b_xdac), .ydac_o(b_ydac), .point_idx_o(b_pidx),
        .npts_o(b_npts), .blank_o(b_blank), .frame_done_o(b_fd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_pt(input int unsigned c, input int i, input logic bl, input logic fd);
        ev_t e;
        e.cyc   = c;
        e.x     = 8'h10 + 8'(i);
        e.y     = 8'h20 + 8'(i);
        e.idx   = 6'(i);
        e.blank = bl;
        e.fd    = fd;
        exp_q.push_back(e);
    endtask

    task automatic exp_zero(input int unsigned c);
        ev_t e;
        e = '0;
        e.cyc   = c;
        e.blank = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: an event is any change of x/y/idx/blank, or a frame_done pulse.
    task automatic monitor();
        ev_t got, prev, e;
        prev = '0;
        forever begin
            @(negedge clk);
            got.cyc   = cyc;
            got.x     = a_xdac;
            got.y     = a_ydac;
            got.idx   = a_pidx;
            got.blank = a_blank;
            got.fd    = a_fd;
            if (mon_on && (got.x != prev.x || got.y != prev.y || got.idx != prev.idx ||
                           got.blank != prev.blank || got.fd)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_event: got cyc=%0d x=%h y=%h idx=%0d blank=%b fd=%b, expected none",
                             got.cyc, got.x, got.y, got.idx, got.blank, got.fd);
                end else begin
                    e = exp_q.pop_front();
                    if (e != got) begin
                        n_errors++;
                        $display("FAIL point_event: got cyc=%0d x=%h y=%h idx=%0d blank=%b fd=%b, expected cyc=%0d x=%h y=%h idx=%0d blank=%b fd=%b",
                                 got.cyc, got.x, got.y, got.idx, got.blank, got.fd,
                                 e.cyc, e.x, e.y, e.idx, e.blank, e.fd);
                    end
                end
            end
            prev = got;
        end
    endtask

    task automatic send_a(input logic [7:0] d);
        a_load_valid = 1'b1;
        a_load_data  = d;
        step();
    endtask

    task automatic send_b(input logic [7:0] d);
        b_load_valid = 1'b1;
        b_load_data  = d;
        step();
    endtask

    task automatic run_start(input logic [1:0] m, input logic [15:0] d, output int unsigned c0);
        mode     = m;
        div_val  = d;
        a_enable = 1'b1;
        c0       = cyc;
    endtask

    initial begin
        int unsigned c0;
        rst_n = 1'b1;
        div_val = 16'd0; mode = 2'b00;
        a_enable = 1'b0; a_load_start = 1'b0; a_load_valid = 1'b0; a_load_data = 8'h00;
        b_enable = 1'b0; b_load_start = 1'b0; b_load_valid = 1'b0; b_load_data = 8'h00;
        fork
            monitor();
        join_none

        // Asynchronous reset mid-clock.
        #2 rst_n = 1'b0;
        #1;
        check("rst_xdac", 32'(a_xdac), 32'h0);
        check("rst_ydac", 32'(a_ydac), 32'h0);
        check("rst_pidx", 32'(a_pidx), 32'h0);
        check("rst_npts", 32'(a_npts), 32'h0);
        check("rst_blank", 32'(a_blank), 32'h1);
        check("rst_fd", 32'(a_fd), 32'h0);
        check("rst_load_ready", 32'(a_load_ready), 32'h1);
        #9 rst_n = 1'b1;
        step();

        // npts=0 with enable: stays idle, blank, no events.
        mon_on = 1'b1;
        a_enable = 1'b1;
        repeat (20) step();
        check("empty_blank", 32'(a_blank), 32'h1);
        check("empty_ready_low", 32'(a_load_ready), 32'h0);
        a_enable = 1'b0;
        repeat (2) step();

        // Load three points into dut_a.
        send_a(8'h10); send_a(8'h20);
        send_a(8'h11); send_a(8'h21);
        send_a(8'h12); send_a(8'h22);
        a_load_valid = 1'b0;
        check("a_npts3", 32'(a_npts), 32'd3);

        // Loop, div_val=3, then abort mid-frame.
        run_start(2'b00, 16'd3, c0);
        for (int k = 0; k < 6; k++) exp_pt(c0 + 5 + 4 * k, k % 3, 1'b0, (k % 3) == 2);
        repeat (27) step();
        a_enable = 1'b0;
        exp_zero(cyc + 1);
        repeat (3) step();

        // One-shot: restarts at point 0, ends blanked on the last point.
        run_start(2'b01, 16'd3, c0);
        exp_pt(c0 + 5, 0, 1'b0, 1'b0);
        exp_pt(c0 + 9, 1, 1'b0, 1'b0);
        exp_pt(c0 + 13, 2, 1'b1, 1'b1);
        repeat (24) step();
        a_enable = 1'b0;
        exp_zero(cyc + 1);
        repeat (3) step();

        // Ping-pong, div_val=1.
        run_start(2'b10, 16'd1, c0);
        for (int k = 0; k < 7; k++) exp_pt(c0 + 3 + 2 * k, pp_seq[k], 1'b0, k == 4);
        repeat (16) step();
        a_enable = 1'b0;
        exp_zero(cyc + 1);
        repeat (3) step();

        // Loop, div_val=0: a new point every clock.
        run_start(2'b00, 16'd0, c0);
        for (int k = 0; k < 5; k++) exp_pt(c0 + 2 + k, k % 3, 1'b0, (k % 3) == 2);
        repeat (6) step();
        a_enable = 1'b0;
        exp_zero(cyc + 1);
        repeat (3) step();
        mon_on = 1'b0;
        check("events_pending", 32'(exp_q.size()), 32'd0);

        // Reset mid-play.
        run_start(2'b00, 16'd3, c0);
        repeat (6) step();
        check("play_x_before_rst", 32'(a_xdac), 32'h10);
        #3;
        rst_n = 1'b0;
        a_enable = 1'b0;
        #1;
        check("midrst_xdac", 32'(a_xdac), 32'h0);
        check("midrst_blank", 32'(a_blank), 32'h1);
        check("midrst_npts", 32'(a_npts), 32'h0);
        check("midrst_load_ready", 32'(a_load_ready), 32'h1);
        #3 rst_n = 1'b1;
        step();

        // dut_b: 12-bit coordinates, two bytes each, LSB first.
        check("b_ready_init", 32'(b_load_ready), 32'h1);
        send_b(8'h34); send_b(8'h12); send_b(8'hCD); send_b(8'hAB);
        b_load_valid = 1'b0;
        check("b_npts1", 32'(b_npts), 32'd1);
        for (int i = 0; i < 12; i++) send_b(b_fill[i]);
        b_load_valid = 1'b0;
        check("b_npts_full", 32'(b_npts), 32'd4);
        check("b_ready_full", 32'(b_load_ready), 32'h0);
        for (int i = 0; i < 4; i++) send_b(8'hFF);
        b_load_valid = 1'b0;
        check("b_npts_extra", 32'(b_npts), 32'd4);

        mode = 2'b11; div_val = 16'd0; b_enable = 1'b1;
        repeat (4) step();
        check("b_xdac_p0", 32'(b_xdac), 32'h234);
        check("b_ydac_p0", 32'(b_ydac), 32'hBCD);
        check("b_pidx_hold", 32'(b_pidx), 32'h0);
        check("b_blank_play", 32'(b_blank), 32'h0);
        b_enable = 1'b0;
        step();
        check("b_abort_xdac", 32'(b_xdac), 32'h0);
        check("b_abort_blank", 32'(b_blank), 32'h1);

        // load_start clears the list; coincident byte dropped, phase cleared.
        b_load_start = 1'b1;
        step();
        b_load_start = 1'b0;
        check("b_clear_npts", 32'(b_npts), 32'd0);
        check("b_clear_ready", 32'(b_load_ready), 32'h1);
        send_b(8'h99);
        b_load_start = 1'b1;
        send_b(8'h77);
        b_load_start = 1'b0;
        b_load_valid = 1'b0;
        check("b_coinc_npts", 32'(b_npts), 32'd0);
        send_b(8'h56); send_b(8'h04); send_b(8'h78); send_b(8'h03);
        b_load_valid = 1'b0;
        check("b_reload_npts", 32'(b_npts), 32'd1);
        b_enable = 1'b1;
        repeat (4) step();
        check("b_xdac_reload", 32'(b_xdac), 32'h456);
        check("b_ydac_reload", 32'(b_ydac), 32'h378);
        b_enable = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/xy_point_player.md
# xy_point_player

Parametrised XY point-list player for the vector-display DAC path. It replaces the fixed divide-by-64 strobe and hard-wired wave generator with a programmable tick divider and a loadable point RAM. It plays the RAM out to the X/Y DAC buses in loop, one-shot, ping-pong or hold mode. It sits between the byte-stream receiver (UART RX) and the `uo_out`/`uio_out` DAC pins.

## Interface
- `COORD_W`, 8: coordinate width, 1..16; bytes per coordinate BPC = (COORD_W+7)/8.
- `DEPTH`, 64: point capacity, power of two, 2..256; IW = log2(DEPTH).
- `DIV_W`, 16: width of the rate divisor.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  high = play; low = park and allow loading.
- `div_val`  in  DIV_W  a tick occurs every div_val+1 clocks.
- `mode`  in  2  00 loop, 01 one-shot, 10 ping-pong, 11 hold.
- `load_start`  in  1  pulse; clears the point list; honoured only while enable=0.
- `load_valid`  in  1  byte-stream valid.
- `load_data`  in  8  byte-stream data.
- `load_ready`  out  1  byte accepted when load_valid & load_ready.
- `xdac`, `ydac`  out  COORD_W  registered DAC codes.
- `point_idx`  out  IW  index of the point currently on the DAC.
- `npts`  out  IW+1  committed point count.
- `blank`  out  1  high when not actively playing.
- `frame_done`  out  1  one-cycle pulse at end of frame.

## Operation
- Reset: xdac=ydac=0, point_idx=0, npts=0, blank=1, frame_done=0, divider=0, state IDLE. The byte phase counter is cleared.
- States: IDLE, PLAY, DONE.
  - IDLE→PLAY when enable=1 and npts≠0.
  - Any state→IDLE when enable=0.
  - PLAY→DONE after the last point in one-shot mode.
  - DONE→IDLE only on enable low.
- Loading:
  - load_ready = (enable=0) & (npts<DEPTH).
  - Each point is BPC bytes of X (LSB first), then BPC bytes of Y.
  - Bits above COORD_W are discarded.
  - The point is written to RAM[npts] and npts increments on the final Y byte.
  - load_start: npts←0 and phase←0. If load_start coincides with a valid byte, load_start wins and the byte is dropped.
- Divider:
  - The counter runs only in PLAY and is held at 0 otherwise.
  - tick = (cnt==div_val), and cnt then returns to 0.
  - div_val=0 gives a tick every clock.
  - A div_val change takes effect at the next compare.
- On each tick in PLAY, the DAC registers load RAM[idx] and point_idx←idx. The next idx is then computed by mode:
  - loop: idx+1, wrapping n−1→0. frame_done when point n−1 is output.
  - one-shot: as loop, but after outputting n−1 go to DONE. Outputs hold the last point, blank=1, frame_done pulses once.
  - ping-pong: direction reverses at 0 and n−1, and endpoints are not repeated (0,1,…,n−1,n−2,…,1,0,1…). frame_done when point 0 is output on a return sweep. n=1 outputs point 0 on every tick.
  - hold: idx is not advanced. The DAC is refreshed from RAM[idx] with no frame_done.
- mode is sampled at each tick. Switching mode keeps the current idx and direction; switching into ping-pong starts upward.
- blank=1 in IDLE and DONE, and in PLAY before the first tick. Otherwise blank=0.
- enable low, any state: next clock xdac=ydac=0, point_idx=0, blank=1. idx and direction reset, and the divider clears.
- A reset mid-load or mid-play returns to the reset values; RAM contents are don't-care.

## Timing
- Tick in cycle k → xdac/ydac/point_idx/blank/frame_done valid in cycle k+1.
- First tick occurs div_val+1 clocks after the first PLAY cycle, and enable→PLAY takes one clock.
- Point period is exactly div_val+1 clocks, with no jitter at wrap or reversal.
- Load throughput is one byte per clock. npts updates the cycle after the accepting edge.
- load_ready drops the cycle after npts reaches DEPTH.

## Test plan
- Reset defaults: assert rst_n=0 asynchronously mid-clock → all outputs 0, blank=1, load_ready=1 with enable=0.
- Loop: COORD_W=8, load points (0x10,0x20),(0x11,0x21),(0x12,0x22), div_val=3, mode=00, enable=1.
  - Required: xdac=10,11,12,10… changing every 4 clocks, first change 5 clocks after enable.
  - frame_done asserted with 12.
- One-shot and ping-pong on the same 3 points:
  - one-shot: 10,11,12 then hold 12, blank=1, a single frame_done.
  - ping-pong: 10,11,12,11,10,11, with frame_done at the second 10.
- Load limits: DEPTH=4, COORD_W=12, send 0x34,0x12,0xCD,0xAB.
  - Required: xdac=0x234, ydac=0xBCD.
  - Continue sending until npts=4 → load_ready=0 and extra bytes are ignored.
  - load_start coincident with a byte → npts=0 and phase=0.
- Abort: drop enable mid-frame → next clock xdac=ydac=0, blank=1, point_idx=0. Re-enable → playback restarts at point 0.
- Edge cases:
  - div_val=0 → a new point every clock.
  - npts=0 with enable=1 → stays IDLE, blank=1, no frame_done.
